ofs_plat_shim_wr_rsp_reorder: RTL and testbench

Parametrised write-response reorder buffer for host-channel shims.
- Allocates one slot per write packet or fence and returns the slot index for use as the FIU-side tag.
- Counts per-line or packed ACKs until each packet is complete, then releases responses strictly in allocation order, with saved metadata restored.
- Unlike the previous generation it accepts unmerged per-line ACKs (no EOP-merge shim needed) and its output honours valid/ready backpressure.
- Sits between the AFU-facing and FIU-facing write channels of the host-channel shim stack.

---
 rtl/ofs_plat_shim_wr_rsp_reorder_pkg.sv | 25 ++
 rtl/ofs_plat_shim_wr_rsp_reorder_if.sv | 43 ++++
 rtl/ofs_plat_wr_rsp_reorder_slots.sv | 89 ++++++++
 rtl/ofs_plat_shim_wr_rsp_reorder.sv | 145 ++++++++++++++
 tb/tb_ofs_plat_shim_wr_rsp_reorder.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/ofs_plat_shim_wr_rsp_reorder_pkg.sv
// ofs_plat_wr_rsp_reorder_pkg
// Shared definitions for the write-response reorder buffer: default
// configuration, slot index / line count / metadata types for that default
// configuration, and the line-counter width helper used by the slot storage.
package ofs_plat_wr_rsp_reorder_pkg;

   localparam int N_ENTRIES_DFLT = 128;
   localparam int MAX_LINES_DFLT = 4;
   localparam int META_W_DFLT    = 16;
   localparam int DATA_W_DFLT    = 32;
   localparam int MIN_FREE_DFLT  = 8;

   // Remaining-line counters hold 0..MAX_LINES, one bit wider than alloc_len.
   function automatic int cnt_w(input int max_lines);
      return $clog2(max_lines) + 1;
   endfunction

   localparam int IDX_W = $clog2(N_ENTRIES_DFLT);
   localparam int CNT_W = cnt_w(MAX_LINES_DFLT);

   typedef logic [IDX_W-1:0]       t_slot_idx;
   typedef logic [CNT_W-1:0]       t_line_cnt;
   typedef logic [META_W_DFLT-1:0] t_slot_meta;

endpackage

// File: rtl/ofs_plat_shim_wr_rsp_reorder_if.sv
// ofs_plat_shim_wr_rsp_reorder_if
// Bundles the allocation, FIU ACK and in-order response channels of the
// write-response reorder buffer.
//   master : shim side (drives alloc, ACKs, rsp_out_ready)
//   slave  : reorder buffer
interface ofs_plat_shim_wr_rsp_reorder_if #(
   parameter int N_ENTRIES = 128,
   parameter int MAX_LINES = 4,
   parameter int META_W    = 16,
   parameter int DATA_W    = 32
);
   localparam int IW = $clog2(N_ENTRIES);
   localparam int LW = $clog2(MAX_LINES);

   logic              alloc_en;
   logic [LW-1:0]     alloc_len;
   logic [META_W-1:0] alloc_meta;
   logic [IW-1:0]     alloc_idx;
   logic              not_full;
   logic              rsp_in_valid;
   logic [IW-1:0]     rsp_in_idx;
   logic              rsp_in_packed;
   logic [DATA_W-1:0] rsp_in_data;
   logic              rsp_out_valid;
   logic              rsp_out_ready;
   logic [DATA_W-1:0] rsp_out_data;
   logic [META_W-1:0] rsp_out_meta;
   logic [IW:0]       in_flight;

   modport master (
      output alloc_en, alloc_len, alloc_meta,
      output rsp_in_valid, rsp_in_idx, rsp_in_packed, rsp_in_data,
      output rsp_out_ready,
      input  alloc_idx, not_full, rsp_out_valid, rsp_out_data, rsp_out_meta, in_flight
   );

   modport slave (
      input  alloc_en, alloc_len, alloc_meta,
      input  rsp_in_valid, rsp_in_idx, rsp_in_packed, rsp_in_data,
      input  rsp_out_ready,
      output alloc_idx, not_full, rsp_out_valid, rsp_out_data, rsp_out_meta, in_flight
   );
endinterface

// File: rtl/ofs_plat_wr_rsp_reorder_slots.sv
// ofs_plat_wr_rsp_reorder_slots
// Per-slot state: remaining-line counters and done bits (reset), plus the
// metadata/payload RAM (no reset). Write ports for alloc and ACK, read at head.
//   alloc_* : initialise slot at alloc_slot
//   ack_*   : count down slot at ack_slot, capture payload on completion
//   head/deq: read head slot, clear its done bit when dequeued
//   ack_illegal (OFS_PLAT_WR_RSP_REORDER_CHECK_EN only): ACK hit a slot with
//             nothing remaining
module ofs_plat_wr_rsp_reorder_slots
   import ofs_plat_wr_rsp_reorder_pkg::*;
#(
   parameter int N_ENTRIES = N_ENTRIES_DFLT,
   parameter int MAX_LINES = MAX_LINES_DFLT,
   parameter int META_W    = META_W_DFLT,
   parameter int DATA_W    = DATA_W_DFLT
)(
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         alloc_we,
   input  logic [$clog2(N_ENTRIES)-1:0] alloc_slot,
   input  logic [$clog2(MAX_LINES)-1:0] alloc_len,
   input  logic [META_W-1:0]            alloc_meta,
   input  logic                         ack_valid,
   input  logic [$clog2(N_ENTRIES)-1:0] ack_slot,
   input  logic                         ack_packed,
   input  logic [DATA_W-1:0]            ack_data,
   input  logic [$clog2(N_ENTRIES)-1:0] head,
   input  logic                         deq,
   output logic                         head_done,
   output logic [DATA_W-1:0]            head_data,
   output logic [META_W-1:0]            head_meta
`ifdef OFS_PLAT_WR_RSP_REORDER_CHECK_EN
  ,output logic                         ack_illegal
`endif
);
   localparam int CW = cnt_w(MAX_LINES);

   logic [N_ENTRIES-1:0][CW-1:0] rem_q, rem_d;
   logic [N_ENTRIES-1:0]         done_q, done_d;
   logic [META_W-1:0]            meta_mem [N_ENTRIES];
   logic [DATA_W-1:0]            data_mem [N_ENTRIES];

   logic [CW-1:0] ack_rem, ack_next;
   logic          ack_ok, ack_last;

   // A slot with nothing remaining is either free or already complete, so a
   // zero count alone identifies every illegal ACK.
   assign ack_rem  = rem_q[ack_slot];
   assign ack_ok   = ack_valid && (ack_rem != '0);
   assign ack_next = ack_packed ? '0 : ack_rem - CW'(1);
   assign ack_last = ack_ok && (ack_next == '0);

`ifdef OFS_PLAT_WR_RSP_REORDER_CHECK_EN
   assign ack_illegal = ack_valid && !ack_ok;
`endif

   always_comb begin
      rem_d  = rem_q;
      done_d = done_q;
      if (ack_ok)   rem_d[ack_slot]  = ack_next;
      if (ack_last) done_d[ack_slot] = 1'b1;
      if (deq)      done_d[head]     = 1'b0;
      // The tail slot can never be the ACK or head slot of a legal stream.
      if (alloc_we) begin
         rem_d[alloc_slot]  = CW'(alloc_len) + CW'(1);
         done_d[alloc_slot] = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rem_q  <= '0;
         done_q <= '0;
      end else begin
         rem_q  <= rem_d;
         done_q <= done_d;
      end
   end

   always_ff @(posedge clk) begin
      if (alloc_we) meta_mem[alloc_slot] <= alloc_meta;
      if (ack_last) data_mem[ack_slot]   <= ack_data;
   end

   assign head_done = done_q[head];
   assign head_data = data_mem[head];
   assign head_meta = meta_mem[head];

endmodule

// File: rtl/ofs_plat_shim_wr_rsp_reorder.sv
// ofs_plat_shim_wr_rsp_reorder
// Write-response reorder buffer. Hands out slot indices as FIU tags, counts
// per-line or packed ACKs, and returns responses in allocation order through
// a single valid/ready output register with the saved metadata restored.
//   clk, reset_n : clock, async active-low reset (deassertion synchronised)
//   bus (slave)  : alloc, FIU ACK and in-order response channels
//   err          : sticky illegal-use flag, present only when
//                  OFS_PLAT_WR_RSP_REORDER_CHECK_EN is defined
module ofs_plat_shim_wr_rsp_reorder
   import ofs_plat_wr_rsp_reorder_pkg::*;
#(
   parameter int N_ENTRIES      = N_ENTRIES_DFLT,
   parameter int MAX_LINES      = MAX_LINES_DFLT,
   parameter int META_W         = META_W_DFLT,
   parameter int DATA_W         = DATA_W_DFLT,
   parameter int MIN_FREE_SLOTS = MIN_FREE_DFLT
)(
   input  logic clk,
   input  logic reset_n,
   ofs_plat_shim_wr_rsp_reorder_if.slave bus
`ifdef OFS_PLAT_WR_RSP_REORDER_CHECK_EN
  ,output logic err
`endif
);
   localparam int IW = $clog2(N_ENTRIES);
   localparam logic [IW:0] FULL_CNT = (IW+1)'(N_ENTRIES);
   localparam logic [IW:0] MIN_FREE = (IW+1)'(MIN_FREE_SLOTS);

   logic [1:0]        rst_sync_q, rst_sync_d;
   logic              rst_n_int;
   logic [IW-1:0]     head_q, head_d, tail_q, tail_d;
   logic [IW:0]       in_flight_q, in_flight_d;
   logic              not_full_q, not_full_d;
   logic              out_valid_q, out_valid_d;
   logic [DATA_W-1:0] out_data_q, out_data_d;
   logic [META_W-1:0] out_meta_q, out_meta_d;
   logic              full, alloc_ok, deq, head_done;
   logic [DATA_W-1:0] head_data;
   logic [META_W-1:0] head_meta;

   // Reset asserts immediately, releases two clocks after reset_n rises.
   assign rst_sync_d = {rst_sync_q[0], 1'b1};
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) rst_sync_q <= '0;
      else          rst_sync_q <= rst_sync_d;
   end
   assign rst_n_int = rst_sync_q[1];

   assign full     = (in_flight_q == FULL_CNT);
   assign alloc_ok = bus.alloc_en && !full;
   // Output register frees up when empty or being consumed this cycle.
   assign deq      = head_done && (!out_valid_q || bus.rsp_out_ready);

   ofs_plat_wr_rsp_reorder_slots #(
      .N_ENTRIES (N_ENTRIES),
      .MAX_LINES (MAX_LINES),
      .META_W    (META_W),
      .DATA_W    (DATA_W)
   ) slots (
      .clk        (clk),
      .rst_n      (rst_n_int),
      .alloc_we   (alloc_ok),
      .alloc_slot (tail_q),
      .alloc_len  (bus.alloc_len),
      .alloc_meta (bus.alloc_meta),
      .ack_valid  (bus.rsp_in_valid),
      .ack_slot   (bus.rsp_in_idx),
      .ack_packed (bus.rsp_in_packed),
      .ack_data   (bus.rsp_in_data),
      .head       (head_q),
      .deq        (deq),
      .head_done  (head_done),
      .head_data  (head_data),
      .head_meta  (head_meta)
`ifdef OFS_PLAT_WR_RSP_REORDER_CHECK_EN
     ,.ack_illegal(ack_illegal)
`endif
   );

   always_comb begin
      tail_d      = tail_q + IW'(alloc_ok);
      head_d      = head_q + IW'(deq);
      in_flight_d = in_flight_q + (IW+1)'(alloc_ok) - (IW+1)'(deq);
      not_full_d  = (FULL_CNT - in_flight_d) >= MIN_FREE;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_meta_d  = out_meta_q;
      if (deq) begin
         out_valid_d = 1'b1;
         out_data_d  = head_data;
         out_meta_d  = head_meta;
      end else if (bus.rsp_out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n_int) begin
      if (!rst_n_int) begin
         head_q      <= '0;
         tail_q      <= '0;
         in_flight_q <= '0;
         not_full_q  <= 1'b1;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_meta_q  <= '0;
      end else begin
         head_q      <= head_d;
         tail_q      <= tail_d;
         in_flight_q <= in_flight_d;
         not_full_q  <= not_full_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_meta_q  <= out_meta_d;
      end
   end

   assign bus.alloc_idx     = tail_q;
   assign bus.not_full      = not_full_q;
   assign bus.rsp_out_valid = out_valid_q;
   assign bus.rsp_out_data  = out_data_q;
   assign bus.rsp_out_meta  = out_meta_q;
   assign bus.in_flight     = in_flight_q;

`ifdef OFS_PLAT_WR_RSP_REORDER_CHECK_EN
   logic ack_illegal;
   logic err_q, err_d;

   assign err_d = err_q || (bus.alloc_en && full) || ack_illegal;

   always_ff @(posedge clk or negedge rst_n_int) begin
      if (!rst_n_int) err_q <= 1'b0;
      else            err_q <= err_d;
   end

   always_ff @(posedge clk) begin
      if (rst_n_int && bus.alloc_en && full)
         $error("wr_rsp_reorder: alloc while full");
      if (rst_n_int && ack_illegal)
         $error("wr_rsp_reorder: ACK to slot %0d with nothing remaining", bus.rsp_in_idx);
   end

   assign err = err_q;
`endif

endmodule

// File: tb/tb_ofs_plat_shim_wr_rsp_reorder.sv
module tb_ofs_plat_shim_wr_rsp_reorder;
   localparam int N    = 16;
   localparam int ML   = 4;
   localparam int MINF = 8;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   ofs_plat_shim_wr_rsp_reorder_if #(.N_ENTRIES(N), .MAX_LINES(ML), .META_W(16), .DATA_W(32)) bus ();

`ifdef OFS_PLAT_WR_RSP_REORDER_CHECK_EN
   logic err;
`endif

   ofs_plat_shim_wr_rsp_reorder #(
      .N_ENTRIES(N), .MAX_LINES(ML), .META_W(16), .DATA_W(32), .MIN_FREE_SLOTS(MINF)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
`ifdef OFS_PLAT_WR_RSP_REORDER_CHECK_EN
     ,.err     (err)
`endif
   );

   // Reference model: outstanding packets in allocation order, and the
   // in-order responses that must appear on the output.
   typedef struct { int idx; logic [15:0] meta; int rem; logic [31:0] data; bit done; } pkt_t;
   typedef struct { logic [31:0] data; logic [15:0] meta; } rsp_t;
   pkt_t pend[$];
   rsp_t exp_q[$];
   int   tail_m = 0;
   int   n_alloc = 0;
   logic rdy = 1'b0;
   int   n_checks = 0;
   int   n_errors = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_ack(input int kidx, input bit pk, input logic [31:0] kd);
      for (int i = 0; i < pend.size(); i++) begin
         if (pend[i].idx == kidx && pend[i].rem > 0) begin
            pend[i].rem = pk ? 0 : pend[i].rem - 1;
            if (pend[i].rem == 0) begin
               pend[i].done = 1'b1;
               pend[i].data = kd;
            end
            break;
         end
      end
   endtask

   task automatic retire();
      rsp_t r;
      while (pend.size() > 0 && pend[0].done) begin
         r.data = pend[0].data;
         r.meta = pend[0].meta;
         exp_q.push_back(r);
         void'(pend.pop_front());
      end
   endtask

   // One clock of stimulus, entered and left at posedge+1.
   task automatic do_cycle(input bit a, input int len, input logic [15:0] m,
                           input bit k, input int kidx, input bit pk, input logic [31:0] kd);
      pkt_t p;
      bus.alloc_en      = a;
      bus.alloc_len     = 2'(len);
      bus.alloc_meta    = m;
      bus.rsp_in_valid  = k;
      bus.rsp_in_idx    = 4'(kidx);
      bus.rsp_in_packed = pk;
      bus.rsp_in_data   = kd;
      bus.rsp_out_ready = rdy;
      if (k) model_ack(kidx, pk, kd);
      if (a && (pend.size() + exp_q.size() < N)) begin
         chk("alloc_idx", 64'(bus.alloc_idx), 64'(tail_m));
         p.idx = tail_m; p.meta = m; p.rem = len + 1; p.data = '0; p.done = 1'b0;
         pend.push_back(p);
         tail_m = (tail_m + 1) % N;
         n_alloc++;
      end
      retire();
      @(posedge clk); #1;
      bus.alloc_en     = 1'b0;
      bus.rsp_in_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) do_cycle(0, 0, 16'h0, 0, 0, 0, 32'h0);
   endtask

   task automatic rnd_step(input bit allow_alloc);
      int cand[$];
      bit a, k, pk;
      int kidx;
      a = allow_alloc && (pend.size() + exp_q.size() < N) && ($urandom_range(0, 2) != 0);
      foreach (pend[i]) if (pend[i].rem > 0) cand.push_back(pend[i].idx);
      k = (cand.size() > 0) && ($urandom_range(0, 3) != 0);
      kidx = k ? cand[$urandom_range(0, cand.size() - 1)] : 0;
      pk = ($urandom_range(0, 3) == 0);
      rdy = ($urandom_range(0, 3) != 0);
      do_cycle(a, int'($urandom_range(0, ML - 1)), 16'($urandom), k, kidx, pk, $urandom);
   endtask

   task automatic drain();
      int n = 0;
      while ((pend.size() > 0 || exp_q.size() > 0) && n < 3000) begin
         rnd_step(0);
         n++;
      end
      if (n >= 3000) chk("drain_timeout", 64'(pend.size() + exp_q.size()), 64'd0);
      rdy = 1'b1;
      idle(2);
      chk("drain_in_flight", 64'(bus.in_flight), 64'd0);
      chk("drain_not_full", 64'(bus.not_full), 64'd1);
   endtask

   // Monitor: every accepted response must be the next one the model expects.
   always @(negedge clk) begin
      rsp_t e;
      if (reset_n && bus.rsp_out_valid && bus.rsp_out_ready) begin
         if (exp_q.size() == 0) chk("unexpected_rsp", 64'(bus.rsp_out_valid), 64'd0);
         else begin
            e = exp_q.pop_front();
            chk("rsp_data", 64'(bus.rsp_out_data), 64'(e.data));
            chk("rsp_meta", 64'(bus.rsp_out_meta), 64'(e.meta));
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.alloc_en = 0; bus.alloc_len = 0; bus.alloc_meta = 0;
      bus.rsp_in_valid = 0; bus.rsp_in_idx = 0; bus.rsp_in_packed = 0; bus.rsp_in_data = 0;
      bus.rsp_out_ready = 0;
      repeat (3) @(posedge clk);
      @(negedge clk) reset_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_valid", 64'(bus.rsp_out_valid), 64'd0);
      chk("rst_in_flight", 64'(bus.in_flight), 64'd0);
      chk("rst_not_full", 64'(bus.not_full), 64'd1);
      chk("rst_alloc_idx", 64'(bus.alloc_idx), 64'd0);

      // 1: three single-line writes completed out of order
      rdy = 1'b1;
      do_cycle(1, 0, 16'hA, 0, 0, 0, 0);
      do_cycle(1, 0, 16'hB, 0, 0, 0, 0);
      do_cycle(1, 0, 16'hC, 0, 0, 0, 0);
      do_cycle(0, 0, 0, 1, 2, 0, 32'h2222);
      do_cycle(0, 0, 0, 1, 0, 0, 32'h0000);
      chk("t1_lat_1cyc", 64'(bus.rsp_out_valid), 64'd0);
      do_cycle(0, 0, 0, 1, 1, 0, 32'h1111);
      chk("t1_lat_2cyc", 64'(bus.rsp_out_valid), 64'd1);
      chk("t1_first_meta", 64'(bus.rsp_out_meta), 64'hA);
      drain();

      // 2: four-line packet, per-line ACKs
      do_cycle(1, 3, 16'h55, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) begin
         do_cycle(0, 0, 0, 1, tail_m == 0 ? N - 1 : tail_m - 1, 0, 32'(i + 7));
         chk("t2_no_early_rsp", 64'(bus.rsp_out_valid), 64'd0);
      end
      do_cycle(0, 0, 0, 1, tail_m == 0 ? N - 1 : tail_m - 1, 0, 32'h1234);
      chk("t2_lat_1cyc", 64'(bus.rsp_out_valid), 64'd0);
      idle(1);
      chk("t2_valid", 64'(bus.rsp_out_valid), 64'd1);
      chk("t2_data", 64'(bus.rsp_out_data), 64'h1234);
      chk("t2_meta", 64'(bus.rsp_out_meta), 64'h55);
      drain();

      // 3: four-line packet, one packed ACK
      do_cycle(1, 3, 16'h77, 0, 0, 0, 0);
      do_cycle(0, 0, 0, 1, tail_m == 0 ? N - 1 : tail_m - 1, 1, 32'hBEEF);
      drain();

      // 4: fill to full without ACKs
      for (int k = 1; k <= N; k++) begin
         do_cycle(1, 0, 16'(k), 0, 0, 0, 0);
         chk("t4_in_flight", 64'(bus.in_flight), 64'(k));
         chk("t4_not_full", 64'(bus.not_full), 64'((N - k) >= MINF));
      end
      do_cycle(1, 0, 16'hFFFF, 0, 0, 0, 0);
      chk("t4_full_in_flight", 64'(bus.in_flight), 64'(N));
      chk("t4_full_alloc_idx", 64'(bus.alloc_idx), 64'(tail_m));
`ifdef OFS_PLAT_WR_RSP_REORDER_CHECK_EN
      chk("t4_err", 64'(err), 64'd1);
`endif
      drain();

      // 5: backpressure with four completed slots
      rdy = 1'b0;
      for (int i = 0; i < 4; i++) do_cycle(1, 0, 16'(16'h100 + i), 0, 0, 0, 0);
      for (int i = 0; i < 4; i++) do_cycle(0, 0, 0, 1, pend[0].idx, 0, 32'(32'hD000 + i));
      idle(2);
      for (int i = 0; i < 5; i++) begin
         chk("t5_hold_valid", 64'(bus.rsp_out_valid), 64'd1);
         chk("t5_hold_data", 64'(bus.rsp_out_data), 64'(exp_q[0].data));
         chk("t5_hold_meta", 64'(bus.rsp_out_meta), 64'(exp_q[0].meta));
         idle(1);
      end
      rdy = 1'b1;
      for (int i = 0; i < 4; i++) begin
         chk("t5_burst_valid", 64'(bus.rsp_out_valid), 64'd1);
         idle(1);
      end
      chk("t5_burst_end", 64'(bus.rsp_out_valid), 64'd0);
      chk("t5_burst_drained", 64'(exp_q.size()), 64'd0);

      // 6: wrap with random completion order, then reset mid-stream
      n_alloc = 0;
      for (int s = 0; s < 4000 && n_alloc < 3 * N; s++) rnd_step(1);
      chk("t6_allocs", 64'(n_alloc >= 3 * N), 64'd1);
      drain();
      for (int s = 0; s < 25; s++) rnd_step(1);
      reset_n = 1'b0;
      #1;
      chk("t6_rst_valid", 64'(bus.rsp_out_valid), 64'd0);
      chk("t6_rst_in_flight", 64'(bus.in_flight), 64'd0);
      chk("t6_rst_not_full", 64'(bus.not_full), 64'd1);
      pend.delete();
      exp_q.delete();
      tail_m = 0;
      bus.alloc_en = 1'b0;
      bus.rsp_in_valid = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk) reset_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("t6_post_rst_alloc_idx", 64'(bus.alloc_idx), 64'd0);
      chk("t6_post_rst_valid", 64'(bus.rsp_out_valid), 64'd0);
      for (int s = 0; s < 60; s++) rnd_step(1);
      drain();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
